rand_stream_receiver: RTL
=========================

Name: rand_stream_receiver

Overview:
- Receiving end of the serial pseudo-random bit stream produced by the team's bit-stream generator.
- The generator transmits a fixed 32-bit seed pattern LSB-first, repeating.
- This block:
  - aligns to the pattern (sync search);
  - deserialises each following W-bit frame into a parallel word;
  - checks every frame against the expected pattern;
  - hands words to downstream logic over a valid/ready interface.

Parameters:
- W, 32: frame width in bits.
- SYNC, 32'h1E55B4E5: expected frame and sync pattern; bit 0 is transmitted first.
- MAX_MISS, 2: consecutive mismatching frames that force loss of lock.
- ERR_W, 16: width of the error counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in is sampled on this edge.
- word_out  out  W  assembled frame; bit k = k-th received bit of the frame.
- word_valid  out  1  word_out holds an untransferred frame.
- word_ready  in  1  downstream accepts word_out.
- locked  out  1  receiver is aligned to SYNC.
- err_cnt  out  ERR_W  total mismatching frames since reset; saturates at all-ones.
- overflow  out  1  sticky: a completed frame was dropped.

Behaviour:
- Reset (rst high at a clk edge): state SEARCH. All outputs clear: word_out=0, word_valid=0, locked=0, err_cnt=0, overflow=0. Internal state clears: shift register=0, fill count=0, bit count=0, miss count=0.
- Reset mid-operation: any partial frame and any held word are discarded. A full resync is required.
- bit_valid low: no internal state changes. The output handshake still operates.
- State SEARCH:
  - On each bit_valid, shift register <= {bit_in, shreg[W-1:1]}.
  - Fill count increments and saturates at W.
  - When the updated fill count is W and the updated shift register equals SYNC: next state is LOCKED. locked=1 from the following cycle. Bit count=0, miss count=0.
  - The sync frame itself is never emitted on word_out.
  - Sliding alignment: a match can occur at any bit offset once W bits are present.
- State LOCKED:
  - On each bit_valid, bit_in is written to frame bit [bit count], then bit count increments.
  - The frame completes on the bit_valid where bit count = W-1; bit count then wraps to 0.
  - Frame check on completion:
    - Match with SYNC: miss count=0.
    - Mismatch: err_cnt+1 (saturating) and miss count+1.
    - If miss count reaches MAX_MISS: state returns to SEARCH, locked=0 the next cycle, fill count=0.
  - Every completed frame is offered for output, including the one that causes loss of lock.
- Output handshake:
  - word_valid rises the cycle after the edge that sampled the W-th bit. Latency is 1 clock from the last bit.
  - Transfer occurs at an edge where word_valid and word_ready are both high.
  - Transfer with no new frame completing: word_valid=0.
  - Transfer and a new frame completing on the same edge: word_out loads the new frame and word_valid stays 1.
  - Frame completes while word_valid=1 and word_ready=0: new frame dropped, word_out unchanged, overflow=1. overflow clears only on rst.
  - word_out is stable while word_valid=1 and no transfer occurs.
- Width rules: err_cnt does not wrap. Bit count and fill count use the width needed to represent W.

Test Plan:
- Lock on aligned sync: after rst, send SYNC LSB-first, 32 bits on consecutive cycles. Required: locked=1 one cycle after the 32nd bit; word_valid stays 0; err_cnt=0.
- Frame delivery: locked, word_ready=1, send SYNC again. Required: word_valid high for exactly one cycle after the 32nd bit; word_out=32'h1E55B4E5; err_cnt=0. Repeat with bit_valid low every other cycle; required result is identical, only slower.
- Unaligned sync: send 5 arbitrary bits (1,0,1,1,0), then SYNC. Required: locked=1 after the 37th bit, not earlier.
- Loss of lock: locked, send 32'h00000000 twice. Required:
  - err_cnt=1 after the first frame, err_cnt=2 after the second;
  - both frames delivered with word_out=0;
  - locked=0 the cycle after the second frame;
  - SYNC then relocks.
- Backpressure: locked, word_ready=0, send two SYNC frames. Required: word_out holds the first frame, overflow=1 after the second. Raise word_ready for one cycle: transfer occurs, word_valid=0, overflow stays 1.
- Reset mid-frame: locked, 10 bits into a frame, assert rst for one cycle. Required: next cycle all outputs at reset values; locked=0; a 22-bit remainder plus SYNC relocks only on a full SYNC match.

Source files
------------

// File: rtl/rand_stream_receiver.sv
// Serial pattern receiver: sync search, frame deserialise and check.
// Completed frames are offered downstream over valid/ready.
module rand_stream_receiver #(
  parameter int             W        = 32,
  parameter logic [W-1:0]   SYNC     = 32'h1E55B4E5,
  parameter int             MAX_MISS = 2,
  parameter int             ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [W-1:0]     word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt,
  output logic             overflow
);

  localparam int CW = $clog2(W + 1);
  localparam int MW = $clog2(MAX_MISS + 1);
  localparam logic [CW-1:0] LP_W   = CW'(W);
  localparam logic [CW-1:0] LP_WM1 = CW'(W - 1);
  localparam logic [MW-1:0] LP_MM  = MW'(MAX_MISS);

  typedef enum logic {S_SEARCH, S_LOCKED} state_t;

  state_t           r_state, w_state_nx;
  logic [W-1:0]     r_sh, w_sh_nx;
  logic [CW-1:0]    r_fill, w_fill_nx;
  logic [CW-1:0]    r_bcnt, w_bcnt_nx;
  logic [MW-1:0]    r_miss, w_miss_nx;
  logic [ERR_W-1:0] r_err, w_err_nx;
  logic [W-1:0]     r_word;
  logic             r_wvalid;
  logic             r_ovf;
  logic             w_done;
  logic             w_xfer;

  always_comb begin
    w_state_nx = r_state;
    w_sh_nx    = r_sh;
    w_fill_nx  = r_fill;
    w_bcnt_nx  = r_bcnt;
    w_miss_nx  = r_miss;
    w_err_nx   = r_err;
    w_done     = 1'b0;
    if (bit_valid) begin
      unique case (r_state)
        S_SEARCH: begin
          w_sh_nx = {bit_in, r_sh[W-1:1]};
          if (r_fill != LP_W)
            w_fill_nx = r_fill + CW'(1);
          if (w_fill_nx == LP_W && w_sh_nx == SYNC) begin
            w_state_nx = S_LOCKED;
            w_bcnt_nx  = '0;
            w_miss_nx  = '0;
          end
        end
        S_LOCKED: begin
          for (int k = 0; k < W; k++)
            if (r_bcnt == CW'(k))
              w_sh_nx[k] = bit_in;
          if (r_bcnt == LP_WM1) begin
            w_done    = 1'b1;
            w_bcnt_nx = '0;
            if (w_sh_nx == SYNC) begin
              w_miss_nx = '0;
            end else begin
              if (r_err != '1)
                w_err_nx = r_err + ERR_W'(1);
              w_miss_nx = r_miss + MW'(1);
              // repeated misses mean we slipped; restart the search
              if (w_miss_nx == LP_MM) begin
                w_state_nx = S_SEARCH;
                w_fill_nx  = '0;
              end
            end
          end else begin
            w_bcnt_nx = r_bcnt + CW'(1);
          end
        end
      endcase
    end
  end

  assign w_xfer = r_wvalid & word_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_SEARCH;
      r_sh     <= '0;
      r_fill   <= '0;
      r_bcnt   <= '0;
      r_miss   <= '0;
      r_err    <= '0;
      r_word   <= '0;
      r_wvalid <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_sh    <= w_sh_nx;
      r_fill  <= w_fill_nx;
      r_bcnt  <= w_bcnt_nx;
      r_miss  <= w_miss_nx;
      r_err   <= w_err_nx;
      if (w_done) begin
        if (!r_wvalid || word_ready) begin
          r_word   <= w_sh_nx;
          r_wvalid <= 1'b1;
        end else begin
          r_ovf <= 1'b1;
        end
      end else if (w_xfer) begin
        r_wvalid <= 1'b0;
      end
    end
  end

  assign word_out   = r_word;
  assign word_valid = r_wvalid;
  assign locked     = (r_state == S_LOCKED);
  assign err_cnt    = r_err;
  assign overflow   = r_ovf;

endmodule
